// File: rtl/mem_responder.sv
// Target-side data memory for the MEM stage: one load/store per handshake,
// performed after a programmable wait, answered with right-aligned data or an ack.
module mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [2:0]  req_len,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END = 33'(ADDR_BASE) + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_wen;
    logic [2:0]  a_len;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] idx_c;
    logic [1:0]       lane_c;
    logic [31:0]      word_c;
    logic [31:0]      word_sh_c;
    logic [31:0]      rdata_c;
    logic [31:0]      wdata_sh_c;
    logic [3:0]       be_base_c;
    logic [3:0]       be_c;
    logic             err_c;
    logic             access_c;
    logic             mem_we_c;

    // Decode the latched request: legality, read extraction and byte enables.
    always_comb begin
        lane_c     = a_addr[1:0];
        idx_c      = IDX_W'((a_addr - ADDR_BASE) >> 2);
        word_c     = mem[idx_c];
        word_sh_c  = word_c >> {lane_c, 3'b000};
        wdata_sh_c = a_wdata << {lane_c, 3'b000};
        err_c      = 1'b0;
        be_base_c  = 4'b0000;
        rdata_c    = 32'd0;
        case (a_len)
            3'd1: begin
                be_base_c = 4'b0001;
                rdata_c   = 32'(word_sh_c[7:0]);
            end
            3'd2: begin
                be_base_c = 4'b0011;
                rdata_c   = 32'(word_sh_c[15:0]);
                err_c     = a_addr[0];
            end
            3'd4: begin
                be_base_c = 4'b1111;
                rdata_c   = word_sh_c;
                err_c     = (a_addr[1:0] != 2'b00);
            end
            default: err_c = 1'b1;
        endcase
        if ({1'b0, a_addr} < {1'b0, ADDR_BASE} || {1'b0, a_addr} >= ADDR_END) begin
            err_c = 1'b1;
        end
        if (err_c || a_wen) begin
            rdata_c = 32'd0;
        end
        be_c     = 4'(be_base_c << lane_c);
        access_c = (state == WAIT) && (cnt == 4'd0) && !rst;
        mem_we_c = access_c && a_wen && !err_c;
    end

    // Word array is not reset; only the addressed byte lanes are written.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_c[b]) begin
                    mem[idx_c][8*b +: 8] <= wdata_sh_c[8*b +: 8];
                end
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            a_addr     <= 32'd0;
            a_wdata    <= 32'd0;
            a_wen      <= 1'b0;
            a_len      <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (req_valid) begin
                        a_addr    <= req_addr;
                        a_wdata   <= req_wdata;
                        a_wen     <= req_wen;
                        a_len     <= req_len;
                        cnt       <= CNT_INIT;
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= rdata_c;
                        resp_err   <= err_c;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'd0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized checks of mem_responder against a byte-array model.
module tb_mem_responder;

    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [2:0]  req_len;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int vectors     = 0;
    int miscompares = 0;

    byte unsigned mdl [4*DEPTH];
    logic [31:0]  last_r;
    logic         last_e;

    mem_responder #(
        .ADDR_BASE  (BASE),
        .DEPTH_WORDS(DEPTH),
        .LATENCY    (LATENCY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wen   (req_wen),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour: byte-addressed array, legality from plain arithmetic.
    function automatic void model(input logic [31:0] addr, input logic wen, input logic [2:0] len,
                                  input logic [31:0] wdata, output logic [31:0] r, output logic e);
        longint a  = longint'(addr);
        longint lo = longint'(BASE);
        longint hi = lo + 4 * longint'(DEPTH);
        int     n  = int'(len);
        e = !(n == 1 || n == 2 || n == 4) || (n == 2 && a % 2 != 0) ||
            (n == 4 && a % 4 != 0) || a < lo || a >= hi;
        r = 32'd0;
        if (!e) begin
            for (int i = 0; i < n; i++) begin
                int off = int'(a - lo) + i;
                if (wen) mdl[off] = wdata[8*i +: 8];
                else     r = r | (32'(mdl[off]) << (8 * i));
            end
        end
    endfunction

    task automatic drive_idle();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wen   = 1'($urandom);
        req_len   = 3'($urandom);
        req_wdata = $urandom;
    endtask

    // One full transaction; latency counts edges from accept to resp_valid.
    task automatic txn(input logic [31:0] addr, input logic wen, input logic [2:0] len,
                       input logic [31:0] wdata, output logic [31:0] r, output logic e,
                       output int lat);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_timeout", 32'(n < 20), 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_len   = len;
        req_wdata = wdata;
        @(posedge clk); #1;
        drive_idle();
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        r = resp_rdata;
        e = resp_err;
        @(posedge clk); #1;
        chk("resp_drop", 32'(resp_valid), 32'd0);
    endtask

    task automatic step(input logic [31:0] addr, input logic wen, input logic [2:0] len,
                        input logic [31:0] wdata);
        logic [31:0] r, exp_r;
        logic        e, exp_e;
        int          lat;
        model(addr, wen, len, wdata, exp_r, exp_e);
        txn(addr, wen, len, wdata, r, e, lat);
        chk($sformatf("err@%h", addr), 32'(e), 32'(exp_e));
        chk($sformatf("rdata@%h", addr), r, exp_r);
        chk("latency", 32'(lat), 32'(LATENCY));
        last_r = r;
        last_e = e;
    endtask

    initial begin
        logic [31:0] exp_r, held_r;
        logic        exp_e;
        int          n;

        rst        = 1'b1;
        resp_ready = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        for (int w = 0; w < int'(DEPTH); w++) begin
            step(BASE + 32'(4 * w), 1'b1, 3'd4, $urandom);
        end

        step(32'h8000_0010, 1'b1, 3'd4, 32'hDEADBEEF);
        chk("t1_store_err", 32'(last_e), 32'd0);
        chk("t1_store_rdata", last_r, 32'd0);
        step(32'h8000_0010, 1'b0, 3'd4, 32'h0);
        chk("t1_load", last_r, 32'hDEADBEEF);

        step(32'h8000_0011, 1'b1, 3'd1, 32'h1234_56AA);
        step(32'h8000_0010, 1'b0, 3'd4, 32'h0);
        chk("t2_word", last_r, 32'hDEADAAEF);
        step(32'h8000_0013, 1'b0, 3'd1, 32'h0);
        chk("t2_byte", last_r, 32'h0000_00DE);

        step(32'h8000_0012, 1'b0, 3'd2, 32'h0);
        chk("t3_half", last_r, 32'h0000_DEAD);
        step(32'h8000_0011, 1'b0, 3'd2, 32'h0);
        chk("t3_misalign_err", 32'(last_e), 32'd1);
        chk("t3_misalign_rdata", last_r, 32'd0);

        step(32'h7FFF_FFFC, 1'b0, 3'd4, 32'h0);
        chk("t4_below", 32'(last_e), 32'd1);
        step(BASE + 32'(4 * DEPTH), 1'b0, 3'd4, 32'h0);
        chk("t4_above", 32'(last_e), 32'd1);
        step(32'h8000_0010, 1'b0, 3'd3, 32'h0);
        chk("t4_len3", 32'(last_e), 32'd1);
        step(32'h8000_0012, 1'b1, 3'd4, 32'h0BAD_0BAD);
        chk("t4_bad_store", 32'(last_e), 32'd1);
        step(32'h8000_0010, 1'b0, 3'd4, 32'h0);
        chk("t4_unchanged", last_r, 32'hDEADAAEF);

        // Response stall with a competing request held on the request port.
        model(32'h8000_0014, 1'b0, 3'd4, 32'h0, exp_r, exp_e);
        req_valid  = 1'b1;
        req_addr   = 32'h8000_0014;
        req_wen    = 1'b0;
        req_len    = 3'd4;
        resp_ready = 1'b0;
        @(posedge clk); #1;
        req_addr  = 32'h8000_0040;
        req_wen   = 1'b1;
        req_wdata = 32'h1234_5678;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        chk("t5_latency", 32'(n), 32'(LATENCY));
        held_r = resp_rdata;
        chk("t5_rdata", held_r, exp_r);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("t5_hold_valid", 32'(resp_valid), 32'd1);
            chk("t5_hold_rdata", resp_rdata, held_r);
            chk("t5_hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        drive_idle();
        chk("t5_done", 32'(resp_valid), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("t5_no_second", 32'(resp_valid), 32'd0);
        end
        step(32'h8000_0040, 1'b0, 3'd4, 32'h0);

        // Reset while the store waits: no write, no response.
        req_valid = 1'b1;
        req_addr  = 32'h8000_0020;
        req_wen   = 1'b1;
        req_len   = 3'd4;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_in_rst_ready", 32'(req_ready), 32'd0);
        chk("t6_in_rst_valid", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        chk("t6_ready_after", 32'(req_ready), 32'd1);
        chk("t6_no_resp", 32'(resp_valid), 32'd0);
        step(32'h8000_0020, 1'b0, 3'd4, 32'h0);

        for (int k = 0; k < 150; k++) begin
            logic [31:0] a;
            logic [2:0]  l;
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'($urandom_range(1, 8));
                1:       a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 8));
                default: a = BASE + 32'($urandom_range(0, 4 * DEPTH - 1));
            endcase
            case ($urandom_range(0, 7))
                0:       l = 3'($urandom);
                1, 2:    l = 3'd1;
                3, 4:    l = 3'd2;
                default: l = 3'd4;
            endcase
            step(a, 1'($urandom), l, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
